// File: rtl/substantivo_sequenciador.sv
// substantivo_sequenciador
//   Front-end controller for the substantive-classifier datapath. Two note
//   players compete for the classifier. The granted player's word is buffered
//   (up to DEPTH notes) and replayed with Pronto strobes spaced GAP idle cycles
//   apart. Two 0000 terminator strobes follow, then Estado_in is sampled LAT
//   cycles later and returned with Resultado_valido.
//
// Ports
//   Clk, Reset             clock (rising) / async active-high reset
//   Req0/1, Nota0/1, Fim0/1 player note offers ({Tom,A,B,C}) and last-note flag
//   Rdy0/1                 registered accept strobes, only the owner's can rise
//   Limpa                  one-cycle classifier clear at grant
//   Pronto, Tom/A/B/C_out  note strobe and note driven to the classifier
//   Estado_in              classifier result
//   Resultado, Resultado_valido, Dono, Truncado  captured result, owner, cut flag
//   Ocupado                controller not idle
module substantivo_sequenciador #(
  parameter int DEPTH = 8,
  parameter int GAP   = 1,
  parameter int LAT   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req0,
  input  logic       Req1,
  input  logic [3:0] Nota0,
  input  logic [3:0] Nota1,
  input  logic       Fim0,
  input  logic       Fim1,
  output logic       Rdy0,
  output logic       Rdy1,
  output logic       Limpa,
  output logic       Pronto,
  output logic       Tom_out,
  output logic       A_out,
  output logic       B_out,
  output logic       C_out,
  input  logic [1:0] Estado_in,
  output logic [1:0] Resultado,
  output logic       Resultado_valido,
  output logic       Dono,
  output logic       Ocupado,
  output logic       Truncado
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);
  localparam logic [3:0]    GAP_V    = 4'(GAP);
  localparam logic [3:0]    LAT_END  = 4'(LAT - 1);

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] CAPTURA = 3'd1;
  localparam logic [2:0] ENVIA   = 3'd2;
  localparam logic [2:0] TERMINA = 3'd3;
  localparam logic [2:0] ESPERA  = 3'd4;
  localparam logic [2:0] ENTREGA = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;      // notes stored for the current word
  logic [CW-1:0] idx;      // note being replayed
  logic [3:0]    gc;       // position inside the Pronto period, 0 = strobe cycle
  logic [3:0]    wc;       // latency wait counter
  logic          tn;       // second terminator strobe pending
  logic          ptr;      // player preferred when both request
  logic          trunc;
  logic [3:0]    mem [DEPTH];

  logic       req_g, rdy_g, fim_g, grant, xfer, is_term, word_end;
  logic [3:0] nota_g, note_out;

  always_comb begin
    req_g  = Dono ? Req1  : Req0;
    rdy_g  = Dono ? Rdy1  : Rdy0;
    fim_g  = Dono ? Fim1  : Fim0;
    nota_g = Dono ? Nota1 : Nota0;
    // Round robin only matters on a tie; a lone requester always wins.
    grant  = (Req0 && Req1) ? ptr : Req1;
    xfer   = (state == CAPTURA) && req_g && rdy_g;
    // Tom alone does not make a note: A=B=C=0 terminates regardless of Tom.
    is_term  = (nota_g[2:0] == 3'b000);
    word_end = is_term || fim_g || (cnt == LAST_CNT);
  end

  always_ff @(posedge Clk) begin
    if (xfer && !is_term) mem[cnt[IW-1:0]] <= nota_g;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state            <= OCIOSO;
      cnt              <= '0;
      idx              <= '0;
      gc               <= '0;
      wc               <= '0;
      tn               <= 1'b0;
      ptr              <= 1'b0;
      trunc            <= 1'b0;
      Dono             <= 1'b0;
      Limpa            <= 1'b0;
      Rdy0             <= 1'b0;
      Rdy1             <= 1'b0;
      Resultado        <= 2'b00;
      Resultado_valido <= 1'b0;
      Truncado         <= 1'b0;
    end else begin
      Limpa            <= 1'b0;
      Resultado_valido <= 1'b0;
      case (state)
        OCIOSO: begin
          if (Req0 || Req1) begin
            state <= CAPTURA;
            Limpa <= 1'b1;
            Dono  <= grant;
            Rdy0  <= ~grant;
            Rdy1  <= grant;
            cnt   <= '0;
            trunc <= 1'b0;
          end
        end
        CAPTURA: begin
          if (xfer) begin
            if (!is_term) cnt <= cnt + 1'b1;
            if (word_end) begin
              Rdy0  <= 1'b0;
              Rdy1  <= 1'b0;
              trunc <= !is_term && !fim_g && (cnt == LAST_CNT);
              idx   <= '0;
              gc    <= '0;
              tn    <= 1'b0;
              // Only a terminator as the very first note leaves the buffer empty.
              state <= (is_term && cnt == '0) ? TERMINA : ENVIA;
            end
          end
        end
        ENVIA: begin
          if (gc == GAP_V) begin
            gc <= '0;
            if (idx + 1'b1 == cnt) begin
              state <= TERMINA;
              tn    <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            gc <= gc + 1'b1;
          end
        end
        TERMINA: begin
          // The classifier decodes the note latched by the previous strobe,
          // so the second 0000 strobe is what flushes the final decode.
          if (tn) begin
            state <= ESPERA;
            wc    <= '0;
          end else if (gc == GAP_V) begin
            gc <= '0;
            tn <= 1'b1;
          end else begin
            gc <= gc + 1'b1;
          end
        end
        ESPERA: begin
          if (wc == LAT_END) begin
            state            <= ENTREGA;
            Resultado        <= Estado_in;
            Resultado_valido <= 1'b1;
            Truncado         <= trunc;
          end else begin
            wc <= wc + 1'b1;
          end
        end
        ENTREGA: begin
          ptr   <= ~Dono;
          cnt   <= '0;
          state <= OCIOSO;
        end
        default: state <= OCIOSO;
      endcase
    end
  end

  // Strobe and note are decoded from state so an async reset clears them at once.
  always_comb begin
    note_out = 4'b0000;
    if (state == ENVIA) note_out = mem[idx[IW-1:0]];
  end

  assign Pronto  = ((state == ENVIA) || (state == TERMINA)) && (gc == 4'd0);
  assign Ocupado = (state != OCIOSO);
  assign {Tom_out, A_out, B_out, C_out} = note_out;

endmodule

// File: tb/tb_substantivo_sequenciador.sv
module tb_substantivo_sequenciador;
  localparam int DEPTH = 8;
  localparam int GAP   = 1;
  localparam int LAT   = 2;

  logic       Clk = 1'b0, Reset = 1'b1;
  logic       Req0 = 1'b0, Req1 = 1'b0, Fim0 = 1'b0, Fim1 = 1'b0;
  logic [3:0] Nota0 = 4'b0, Nota1 = 4'b0;
  logic       Rdy0, Rdy1, Limpa, Pronto, Tom_out, A_out, B_out, C_out;
  logic [1:0] Estado_in, Resultado;
  logic       Resultado_valido, Dono, Ocupado, Truncado;
  logic [1:0] est0 = 2'b00, est1 = 2'b00;

  // Classifier stand-in: each player's word is given a known result.
  assign Estado_in = Dono ? est1 : est0;

  substantivo_sequenciador #(.DEPTH(DEPTH), .GAP(GAP), .LAT(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .Nota0(Nota0), .Nota1(Nota1),
    .Fim0(Fim0), .Fim1(Fim1), .Rdy0(Rdy0), .Rdy1(Rdy1), .Limpa(Limpa), .Pronto(Pronto),
    .Tom_out(Tom_out), .A_out(A_out), .B_out(B_out), .C_out(C_out), .Estado_in(Estado_in),
    .Resultado(Resultado), .Resultado_valido(Resultado_valido), .Dono(Dono),
    .Ocupado(Ocupado), .Truncado(Truncado));

  always #5 Clk = ~Clk;

  int n_cmp = 0, n_bad = 0, n_valid = 0, cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       dono;
    logic [1:0] res;
    bit         tr;
    int         npr;
    logic [63:0] notes;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Monitor: collects every Pronto note of a word and checks the result record.
  int          cur_n = 0, limpa_n = 0, last_pr = 0;
  logic [63:0] cur_notes = '0;
  always @(negedge Clk) begin
    cyc++;
    if (Reset) begin
      cur_n = 0; cur_notes = '0; limpa_n = 0;
    end else begin
      check("rdy_exclusive", 64'(Rdy0 & Rdy1), 64'd0);
      if (Limpa) limpa_n++;
      if (Pronto) begin
        if (cur_n > 0) check("pronto_period", 64'(cyc - last_pr), 64'(GAP + 1));
        if (cur_n < 16) cur_notes[4*cur_n +: 4] = {Tom_out, A_out, B_out, C_out};
        cur_n++;
        last_pr = cyc;
      end
      if (Resultado_valido) begin
        n_valid++;
        if (exp_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("dono", 64'(Dono), 64'(mon_e.dono));
          check("resultado", 64'(Resultado), 64'(mon_e.res));
          check("truncado", 64'(Truncado), 64'(mon_e.tr));
          check("pronto_count", 64'(cur_n), 64'(mon_e.npr));
          check("pronto_notes", cur_notes, mon_e.notes);
          check("limpa_count", 64'(limpa_n), 64'd1);
          check("valid_latency", 64'(cyc - last_pr), 64'(LAT + 1));
        end
        cur_n = 0; cur_notes = '0; limpa_n = 0;
      end
    end
  end

  task automatic set_req(input int p, input bit r, input logic [3:0] nt, input bit f);
    if (p == 0) begin Req0 = r; Nota0 = nt; Fim0 = f; end
    else        begin Req1 = r; Nota1 = nt; Fim1 = f; end
  endtask

  // Player model: offers notes in order; notes past the word end must never be accepted.
  task automatic drive_word(input int p, input int n, input logic [63:0] notes,
                            input logic [15:0] fim, input int consumed, input bit pause);
    bit got, rq, rdy;
    int t;
    for (int i = 0; i < n; i++) begin
      if (i < consumed) begin
        got = 0; t = 0;
        while (!got && t < 3000) begin
          rq = !(pause && $urandom_range(0, 3) == 0);
          set_req(p, rq, notes[4*i +: 4], fim[i]);
          rdy = (p == 0) ? Rdy0 : Rdy1;
          @(posedge Clk);
          got = rq && rdy;
          @(negedge Clk);
          t++;
        end
        if (!got) check("transfer_timeout", 64'd0, 64'd1);
      end else begin
        set_req(p, 1'b1, notes[4*i +: 4], fim[i]);
        for (int k = 0; k < 4; k++) begin
          check("rdy_after_word_end", 64'((p == 0) ? Rdy0 : Rdy1), 64'd0);
          @(negedge Clk);
        end
        break;
      end
    end
    set_req(p, 1'b0, 4'b0, 1'b0);
  endtask

  task automatic wait_valid(input int target);
    int t = 0;
    while (n_valid < target && t < 2000) begin @(negedge Clk); t++; end
    check("valid_timeout", 64'(n_valid >= target), 64'd1);
  endtask

  // Reference: word contents from the list of offered notes.
  task automatic ref_word(input int n, input logic [63:0] notes, input logic [15:0] fim,
                          output int consumed, output int stored, output bit tr,
                          output logic [63:0] out);
    logic [3:0] nt;
    consumed = n; stored = 0; tr = 0; out = '0;
    for (int i = 0; i < n; i++) begin
      nt = notes[4*i +: 4];
      if (nt[2:0] == 3'b000) begin consumed = i + 1; break; end
      out[4*stored +: 4] = nt;
      stored++;
      if (fim[i]) begin consumed = i + 1; break; end
      if (stored == DEPTH) begin tr = 1; consumed = i + 1; break; end
    end
  endtask

  typedef struct {
    int          p;
    int          n;
    logic [63:0] notes;
    logic [15:0] fim;
    logic [1:0]  est;
    int          npr;
    bit          tr;
    int          consumed;
  } vec_t;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv[7];
    int          target, last, first, k;
    int          p, n, consumed, stored;
    bit          tr, found;
    logic [63:0] notes, exp_notes, mask;
    logic [15:0] fim;
    logic [3:0]  nt;
    logic [1:0]  est;

    // note0 sits in the low nibble
    tv[0] = '{0, 1, 64'h3,        16'h01, 2'b11, 3,  0, 1};
    tv[1] = '{1, 2, 64'h05,       16'h00, 2'b01, 3,  0, 2};
    tv[2] = '{0, 9, 64'hA97654321, 16'h00, 2'b10, 10, 1, 8};
    tv[3] = '{1, 1, 64'h0,        16'h00, 2'b00, 2,  0, 1};
    tv[4] = '{0, 1, 64'h8,        16'h00, 2'b10, 2,  0, 1};
    tv[5] = '{1, 8, 64'hFEDCBA91, 16'h80, 2'b11, 10, 0, 8};
    tv[6] = '{0, 3, 64'h764,      16'h02, 2'b01, 4,  0, 2};

    target = 0;
    last   = 1;

    repeat (2) @(negedge Clk);
    check("reset_outputs", 64'({Rdy0, Rdy1, Limpa, Pronto, Tom_out, A_out, B_out, C_out,
                                Resultado, Resultado_valido, Dono, Ocupado, Truncado}), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("idle_outputs", 64'({Rdy0, Rdy1, Limpa, Pronto, Ocupado, Resultado_valido}), 64'd0);

    // Simultaneous requests twice: the tie must alternate starting with player 0.
    for (int r = 0; r < 2; r++) begin
      est0 = 2'b11; est1 = 2'b10;
      first = (last == 1) ? 0 : 1;
      if (first == 0) begin
        exp_q.push_back('{1'b0, 2'b11, 1'b0, 3, 64'h3});
        exp_q.push_back('{1'b1, 2'b10, 1'b0, 3, 64'h6});
      end else begin
        exp_q.push_back('{1'b1, 2'b10, 1'b0, 3, 64'h6});
        exp_q.push_back('{1'b0, 2'b11, 1'b0, 3, 64'h3});
      end
      fork
        drive_word(0, 1, 64'h3, 16'h1, 1, 0);
        drive_word(1, 1, 64'h6, 16'h1, 1, 0);
      join
      target += 2;
      wait_valid(target);
      last = 1 - first;
    end

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      if (tv[i].p == 0) est0 = tv[i].est; else est1 = tv[i].est;
      mask = (64'd1 << (4 * (tv[i].npr - 2))) - 64'd1;
      exp_q.push_back('{1'(tv[i].p), tv[i].est, tv[i].tr, tv[i].npr, tv[i].notes & mask});
      drive_word(tv[i].p, tv[i].n, tv[i].notes, tv[i].fim, tv[i].consumed, 0);
      target++;
      wait_valid(target);
      check("table_resultado", 64'(Resultado), 64'(tv[i].est));
      check("table_truncado", 64'(Truncado), 64'(tv[i].tr));
      last = tv[i].p;
    end

    // Reset during the third note strobe aborts the word.
    est0 = 2'b11;
    found = 0;
    fork
      drive_word(0, 4, 64'h4321, 16'h8, 4, 0);
      begin
        k = 0;
        for (int c = 0; c < 500 && !found; c++) begin
          @(posedge Clk); #1;
          if (Pronto) k++;
          if (k == 3) found = 1;
        end
      end
    join
    check("third_pronto_seen", 64'(found), 64'd1);
    Reset = 1'b1;
    #1;
    check("abort_outputs", 64'({Pronto, Ocupado, Rdy0, Rdy1, Tom_out, A_out, B_out, C_out,
                                Resultado_valido, Limpa}), 64'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    last = 1;
    k = n_valid;
    repeat (20) @(negedge Clk);
    check("no_valid_after_abort", 64'(n_valid), 64'(k));
    est1 = 2'b01;
    exp_q.push_back('{1'b1, 2'b01, 1'b0, 3, 64'h2});
    drive_word(1, 1, 64'h2, 16'h1, 1, 0);
    target++;
    wait_valid(target);
    last = 1;

    // Random words against the reference.
    for (int w = 0; w < 25; w++) begin
      p = $urandom_range(0, 1);
      n = $urandom_range(1, 11);
      notes = '0; fim = '0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) nt = {1'($urandom_range(0, 1)), 3'b000};
        else                           nt = {1'($urandom_range(0, 1)), 3'($urandom_range(1, 7))};
        notes[4*i +: 4] = nt;
        fim[i] = ($urandom_range(0, 9) == 0);
      end
      fim[n-1] = 1'b1;
      ref_word(n, notes, fim, consumed, stored, tr, exp_notes);
      est = 2'($urandom_range(0, 3));
      if (p == 0) est0 = est; else est1 = est;
      exp_q.push_back('{1'(p), est, tr, stored + 2, exp_notes});
      drive_word(p, n, notes, fim, consumed, 1);
      target++;
      wait_valid(target);
      last = p;
    end

    repeat (5) @(negedge Clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
